// File: rtl/add_sum_buffer_pkg.sv
// add_sum_buffer shared types: FSM state encodings and entry sizing helpers.
// Imported by the buffer top and its testbench.
package add_sum_buffer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // One entry is the sum plus the collapsed carry bit.
  function automatic int add_entry_w(input int w);
    return w + 1;
  endfunction

  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ST_ONE:  n = 2'd1;
      ST_FULL: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/add_sum_buffer_if.sv
// add_sum_buffer handshake bundle: adder side (in_*) and consumer side (out_*).
// slave = the buffer, master = the surrounding producer/consumer.
interface add_sum_buffer_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_z;
  logic [WIDTH-1:0] in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_z;
  logic             out_cout;

  modport slave (
    input  in_valid, in_z, in_cout, out_ready,
    output in_ready, out_valid, out_z, out_cout
  );

  modport master (
    output in_valid, in_z, in_cout, out_ready,
    input  in_ready, out_valid, out_z, out_cout
  );

endinterface

// File: rtl/add_buf_entry.sv
// add_buf_entry: one load-enable storage slot of the sum buffer.
// Clears to zero on asynchronous active-low reset.
module add_buf_entry #(
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/add_sum_buffer.sv
// add_sum_buffer: registered 2-entry skid buffer behind the Add full-adder.
// Optional ADD_SUM_BUFFER_CARRY_STICKY_EN adds carry_sticky / clr_sticky.
module add_sum_buffer
  import add_sum_buffer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  add_sum_buffer_if.slave     bus,
`ifdef ADD_SUM_BUFFER_CARRY_STICKY_EN
  output logic                carry_sticky,
  input  logic                clr_sticky,
`endif
  output logic [1:0]          occupancy
);

  localparam int EW = add_entry_w(WIDTH);

  state_e        r_state;
  state_e        w_nxt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [1:0]    r_occ;
  logic          w_push;
  logic          w_pop;
  logic          w_main_ld;
  logic          w_skid_ld;
  logic [EW-1:0] w_in_ent;
  logic [EW-1:0] w_main_d;
  logic [EW-1:0] w_main_q;
  logic [EW-1:0] w_skid_q;

  assign w_push   = bus.in_valid & r_in_ready;
  assign w_pop    = r_out_valid & bus.out_ready;
  assign w_in_ent = {|bus.in_cout, bus.in_z};

  always_comb begin
    w_nxt     = r_state;
    w_main_ld = 1'b0;
    w_skid_ld = 1'b0;
    w_main_d  = w_in_ent;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_nxt     = ST_ONE;
          w_main_ld = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_push && w_pop) begin
          w_main_ld = 1'b1;
        end else if (w_push) begin
          w_nxt     = ST_FULL;
          w_skid_ld = 1'b1;
        end else if (w_pop) begin
          w_nxt     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the skid-to-main move can happen.
        if (w_pop) begin
          w_nxt     = ST_ONE;
          w_main_ld = 1'b1;
          w_main_d  = w_skid_q;
        end
      end
      default: begin
        w_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_state     <= w_nxt;
      r_in_ready  <= (w_nxt != ST_FULL);
      r_out_valid <= (w_nxt != ST_EMPTY);
      r_occ       <= occ_of(w_nxt);
    end
  end

  add_buf_entry #(.W(EW)) u_main (
    .Clk  (Clk),
    .Rst  (Rst),
    .i_ld (w_main_ld),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  add_buf_entry #(.W(EW)) u_skid (
    .Clk  (Clk),
    .Rst  (Rst),
    .i_ld (w_skid_ld),
    .i_d  (w_in_ent),
    .o_q  (w_skid_q)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_z     = w_main_q[WIDTH-1:0];
  assign bus.out_cout  = w_main_q[WIDTH];
  assign occupancy     = r_occ;

`ifdef ADD_SUM_BUFFER_CARRY_STICKY_EN
  logic r_sticky;

  // A carry pop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_sticky <= 1'b0;
    end else if (w_pop && w_main_q[WIDTH]) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign carry_sticky = r_sticky;
`endif

endmodule
